// File: rtl/id_hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight register writers and produces forwarding selects and load-use stalls.
// Optional macro STALL_CNT_EN builds a saturating load-use stall cycle counter on stall_cycles.
module id_hazard_scoreboard #(
  parameter int NUM_FWD_STAGES = 3,
  parameter int REG_IDX_W      = 5,
  parameter int LOAD_LAT       = 1,
  parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid_inst,
  input  logic [REG_IDX_W-1:0] id_rs1_idx,
  input  logic [REG_IDX_W-1:0] id_rs2_idx,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic                 id_reg_wr,
  input  logic [REG_IDX_W-1:0] id_dest_idx,
  input  logic                 id_rd_mem,
  input  logic                 flush,
  input  logic                 pipe_hold,
  output logic [SEL_W-1:0]     fwd_a_sel,
  output logic [SEL_W-1:0]     fwd_b_sel,
  output logic                 id_stall,
  output logic                 issue_valid,
  output logic [SEL_W-1:0]     inflight_cnt,
  output logic [31:0]          stall_cycles
);

  logic [NUM_FWD_STAGES-1:0] slot_valid;
  logic [NUM_FWD_STAGES-1:0] slot_load;
  logic [REG_IDX_W-1:0]      slot_dest [NUM_FWD_STAGES];

  logic lu_a;
  logic lu_b;
  logic load_use;
  logic alloc;

  // Walk from oldest to youngest so the lowest matching slot overwrites any older match.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    lu_a      = 1'b0;
    lu_b      = 1'b0;
    for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
      if (slot_valid[k] && (slot_dest[k] == id_rs1_idx) && (id_rs1_idx != '0) &&
          id_rs1_used && id_valid_inst) begin
        fwd_a_sel = SEL_W'(k + 1);
        lu_a      = slot_load[k] && (k < LOAD_LAT);
      end
      if (slot_valid[k] && (slot_dest[k] == id_rs2_idx) && (id_rs2_idx != '0) &&
          id_rs2_used && id_valid_inst) begin
        fwd_b_sel = SEL_W'(k + 1);
        lu_b      = slot_load[k] && (k < LOAD_LAT);
      end
    end
  end

  always_comb begin
    inflight_cnt = '0;
    for (int k = 0; k < NUM_FWD_STAGES; k++) begin
      inflight_cnt = inflight_cnt + SEL_W'(slot_valid[k]);
    end
  end

  assign load_use    = lu_a | lu_b;
  assign id_stall    = pipe_hold | (load_use & ~flush);
  assign issue_valid = id_valid_inst & ~flush & ~id_stall;
  assign alloc       = issue_valid & id_reg_wr & (id_dest_idx != '0);

  // A downstream hold freezes every slot; otherwise the scoreboard shifts one stage toward WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= '0;
      slot_load  <= '0;
      for (int k = 0; k < NUM_FWD_STAGES; k++) begin
        slot_dest[k] <= '0;
      end
    end else if (!pipe_hold) begin
      for (int k = NUM_FWD_STAGES - 1; k >= 1; k--) begin
        slot_valid[k] <= slot_valid[k-1];
        slot_load[k]  <= slot_load[k-1];
        slot_dest[k]  <= slot_dest[k-1];
      end
      slot_valid[0] <= alloc;
      slot_load[0]  <= alloc & id_rd_mem;
      slot_dest[0]  <= id_dest_idx;
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (load_use && !flush && !pipe_hold && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
- Parametrised successor to the fixed three-way forwarding compare in the decode stage.
- Tracks in-flight register writers in a shift-register scoreboard that is NUM_FWD_STAGES deep.
- Produces per-operand forwarding selects and a load-use stall.
- Sits beside id_stage. Drives the ID/EX bubble insert and the IF/ID hold, and honours a downstream pipeline hold and a branch flush.

Parameters:
- NUM_FWD_STAGES, 3: pipeline stages between ID and register-file write (EX, MEM, WB); scoreboard depth.
- REG_IDX_W, 5: register index width.
- LOAD_LAT, 1: loads sitting in slots 0..LOAD_LAT-1 cannot forward and force a stall.
- SEL_W, $clog2(NUM_FWD_STAGES+1): forwarding select width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- id_valid_inst  in  1  ID holds a valid instruction
- id_rs1_idx  in  REG_IDX_W  rs1 index
- id_rs2_idx  in  REG_IDX_W  rs2 index
- id_rs1_used  in  1  instruction reads rs1 (decoder reg_fields[0])
- id_rs2_used  in  1  instruction reads rs2 (decoder reg_fields[1])
- id_reg_wr  in  1  instruction writes rd
- id_dest_idx  in  REG_IDX_W  rd index
- id_rd_mem  in  1  instruction is a load
- flush  in  1  taken branch/jump; kill the ID instruction
- pipe_hold  in  1  downstream stall; freeze scoreboard
- fwd_a_sel  out  SEL_W  0 = regfile, k = forward from slot k-1
- fwd_b_sel  out  SEL_W  as fwd_a_sel, for rs2
- id_stall  out  1  hold PC and IF/ID
- issue_valid  out  1  ID instruction advances into ID/EX this cycle
- inflight_cnt  out  SEL_W  number of valid writer slots
- stall_cycles  out  32  load-use stall cycle count (only with the optional feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset: all slots invalid; the stall_cycles counter is cleared. Outputs derive from state, so fwd_a_sel=0, fwd_b_sel=0, id_stall=0, inflight_cnt=0 in the cycle after reset.
  - issue_valid and id_stall may follow the live ID inputs while rst is high. Consumers qualify them with rst.
- Slot contents: {valid, dest, is_load}. Slot 0 is EX and slot NUM_FWD_STAGES-1 is WB.
- Only writers are stored: valid = issue_valid & id_reg_wr & (id_dest_idx != 0).
- Match rule, operand A: slot k matches when valid[k] & dest[k]==id_rs1_idx & id_rs1_idx!=0 & id_rs1_used & id_valid_inst.
- fwd_a_sel: k+1 for the lowest matching k (youngest writer wins); 0 if no slot matches. Operand B is identical using the rs2 signals and gives fwd_b_sel.
- Load-use condition: the lowest-matching slot for either operand has is_load=1 and k < LOAD_LAT. A load at k >= LOAD_LAT forwards normally.
- Combinational outputs, computed from the current state and inputs:
  - id_stall = pipe_hold | (load_use & ~flush)
  - issue_valid = id_valid_inst & ~flush & ~id_stall
- Sequential update, on a clock edge with rst=0:
  - pipe_hold=1: all slots hold. pipe_hold wins over load-use and flush for the scoreboard.
  - Otherwise: slot[k] <= slot[k-1] for k >= 1. Slot 0 takes the ID instruction if issue_valid, else a bubble (valid=0).
  - The oldest slot falls off the end.
- inflight_cnt: population count of the valid bits.
- Simultaneous events:
  - flush with load-use: flush wins; no stall, bubble inserted.
  - rst mid-stall: all slots cleared next cycle; the stall drops on the following cycle.
  - Same dest in several slots: the lowest k (youngest writer) wins.
- Latency: zero-cycle combinational selects from registered state. A load-use stall lasts exactly LOAD_LAT - k cycles when there is no hold.

Optional Feature:
- Macro: STALL_CNT_EN.
- Defined: stall_cycles increments by 1 on each clock with rst=0, load_use=1, flush=0 and pipe_hold=0. It saturates at 32'hFFFFFFFF and is cleared by rst.
- Undefined: stall_cycles is tied to 0 and no counter flops are built.

Test Plan:
1. Back-to-back dependency: issue add x5; next cycle an instruction with rs1=x5, rs1_used=1 -> fwd_a_sel=1, id_stall=0.
2. Two older writers: x5 in slot 2 (WB) and slot 1 (MEM), consumer rs2=x5 -> fwd_b_sel=2 (youngest wins); with rs2_used=0 -> fwd_b_sel=0.
3. Load-use, LOAD_LAT=1: lw x7 then add rs1=x7 -> id_stall=1 for 1 cycle, bubble in slot 0, then fwd_a_sel=2 and issue_valid=1; with STALL_CNT_EN, stall_cycles=1.
4. x0 destination and source: writer to x0 followed by a reader of x0 -> no slot allocated, inflight_cnt unchanged, fwd_a_sel=0.
5. pipe_hold=1 for 3 cycles with 2 valid slots -> slots frozen, inflight_cnt=2, id_stall=1, issue_valid=0 throughout; on release the shift resumes.
6. flush asserted during a load-use stall, then rst=1 mid-stream -> flush cycle: id_stall=0, issue_valid=0; after rst: inflight_cnt=0, fwd selects 0, stall_cycles=0.
